pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central pipeline controller for the 5-stage MIPS core. Generates the stall, bubble and exception-flush controls consumed by the F/D/E/M/W pipeline registers. It holds the multiply/divide busy countdown and applies Tuse/Tnew dependency checks against the E and M stages. It also arbitrates between data stalls, MDU stalls, ERET/EPC hazards and exception requests.

## Interface
- MULT_CYC, 5, busy cycles for mult/multu after issue
- DIV_CYC, 10, busy cycles for div/divu after issue
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high; clears all internal state
- rs_d, rt_d  in  5  source register numbers of the D-stage instruction
- tuse_rs_d, tuse_rt_d  in  2  Tuse of rs/rt in D; 3 = operand not used
- md_use_d  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
- eret_d  in  1  D instruction is eret
- a3_e, a3_m  in  5  destination register in E / M
- rfwr_e, rfwr_m  in  1  E / M instruction writes the GPR file
- tnew_e, tnew_m  in  2  remaining Tnew in E / M
- epc_wr_e, epc_wr_m  in  1  E / M instruction is mtc0 to EPC ($14)
- md_start_e  in  1  mult/div issuing in E this cycle
- md_is_div_e  in  1  the issuing op is div/divu
- exc_req_m  in  1  exception/interrupt taken at M this cycle
- stall  out  1  hold the PC and the D register (D stall input)
- clr_e  out  1  insert a bubble into the E register (E stall input)
- req  out  1  flush all pipeline registers and redirect the PC to the handler
- md_busy  out  1  MDU busy (debug/visibility)

## Operation
- Data hazard per source s in {rs, rt}: hazard when s_d != 0, and either (rfwr_e & a3_e == s_d & tnew_e > tuse_s_d) or (rfwr_m & a3_m == s_d & tnew_m > tuse_s_d). tuse = 3 never hazards.
- MDU countdown `cnt`, width clog2(max(MULT_CYC, DIV_CYC) + 1):
  - md_start_e & !exc_req_m at a clock edge loads DIV_CYC if md_is_div_e, else MULT_CYC.
  - Otherwise cnt decrements while nonzero.
- md_busy = md_start_e | (cnt != 0).
- MDU stall = md_use_d & md_busy.
- ERET stall = eret_d & (epc_wr_e | epc_wr_m).
- Raw stall = data | MDU | ERET.
- Priority: req = exc_req_m overrides everything; stall = raw & !req; clr_e = stall.
- On exception:
  - md_start_e is ignored, because the E instruction is younger and is being flushed.
  - A countdown already running is not cleared; the MDU result of an older mult/div still completes.
- md_start_e during a nonzero cnt is a protocol error (such an op would have stalled in D). The reload value wins.

## Timing
- stall, clr_e and req are combinational from inputs and cnt in the same cycle. No added latency.
- md_start_e in cycle t: md_busy = 1 in cycles t .. t+N and 0 in cycle t+N+1, with N = MULT_CYC or DIV_CYC.
  - An mfhi held in D is released in cycle t+N+1.
- Reset (async, any time, including mid-countdown): cnt = 0 immediately. With idle inputs, stall = clr_e = req = md_busy = 0.
- Simultaneous exc_req_m and any stall source: req = 1, stall = 0, clr_e = 0.
- Simultaneous data and MDU stall: one stall, no double counting; cnt keeps decrementing during stalls.

## Structure
- The shared package cpu_pkg holds:
  - the TUSE_NONE = 2'd3 constant;
  - the MULT_CYC/DIV_CYC defaults;
  - the handler address 32'h0000_4180 used by the pipeline registers on req.
- One sub-module, md_busy_cnt: the countdown with load/decrement/busy. The hazard compare logic stays in the top module.

## Test plan
- rfwr_e = 1, a3_e = 8, tnew_e = 2; rs_d = 8, tuse_rs_d = 0 -> stall = clr_e = 1. Same with tuse_rs_d = 2 -> stall = 0.
- a3_m = 0, rs_d = 0 with rfwr_m = 1, tnew_m = 1 -> stall = 0 (the $0 exemption).
- md_start_e = 1, md_is_div_e = 1 in cycle 0; md_use_d = 1 from cycle 1 -> stall = 1 in cycles 1..10 and 0 in cycle 11. Mult: 0 in cycle 6.
- md_start_e = 1 with exc_req_m = 1 -> req = 1, stall = 0, md_busy = 0 next cycle (no load).
- eret_d = 1 with epc_wr_m = 1 -> stall = 1. With epc_wr_m = 0 and no other hazard -> stall = 0.
- Reset asserted at cnt = 4 during a div -> md_busy = 0 immediately; after release, md_use_d = 1 gives no stall.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants for the 5-stage core pipeline control.
// Tuse sentinel, MDU latencies and exception handler address.
package cpu_pkg;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;

    localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

endpackage

// File: rtl/md_busy_cnt.sv
// Multiply/divide busy countdown.
// Loads the op latency on issue and counts down to zero.
module md_busy_cnt
    import cpu_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF,
    localparam int MAXC    = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC,
    localparam int CW      = $clog2(MAXC + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          is_div,
    output logic [CW-1:0] cnt
);

    localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYC);
    localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYC);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= is_div ? DIV_LD : MULT_LD;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/bubble/flush controller.
// Combines data, MDU and ERET hazards under exception priority.
module pipe_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_d,
    input  logic [4:0] rt_d,
    input  logic [1:0] tuse_rs_d,
    input  logic [1:0] tuse_rt_d,
    input  logic       md_use_d,
    input  logic       eret_d,
    input  logic [4:0] a3_e,
    input  logic [4:0] a3_m,
    input  logic       rfwr_e,
    input  logic       rfwr_m,
    input  logic [1:0] tnew_e,
    input  logic [1:0] tnew_m,
    input  logic       epc_wr_e,
    input  logic       epc_wr_m,
    input  logic       md_start_e,
    input  logic       md_is_div_e,
    input  logic       exc_req_m,
    output logic       stall,
    output logic       clr_e,
    output logic       req,
    output logic       md_busy
);

    localparam int MAXC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CW   = $clog2(MAXC + 1);

    logic [CW-1:0] cnt;
    logic          hz_rs;
    logic          hz_rt;
    logic          hz_data;
    logic          hz_md;
    logic          hz_eret;
    logic          raw;

    // A younger op in E is flushed on exception, so it must not load.
    md_busy_cnt #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .load   (md_start_e & ~exc_req_m),
        .is_div (md_is_div_e),
        .cnt    (cnt)
    );

    assign hz_rs = (rs_d != 5'd0) && (tuse_rs_d != TUSE_NONE) && (
        (rfwr_e && a3_e == rs_d && tnew_e > tuse_rs_d) ||
        (rfwr_m && a3_m == rs_d && tnew_m > tuse_rs_d));

    assign hz_rt = (rt_d != 5'd0) && (tuse_rt_d != TUSE_NONE) && (
        (rfwr_e && a3_e == rt_d && tnew_e > tuse_rt_d) ||
        (rfwr_m && a3_m == rt_d && tnew_m > tuse_rt_d));

    assign hz_data = hz_rs | hz_rt;
    assign md_busy = md_start_e | (cnt != '0);
    assign hz_md   = md_use_d & md_busy;
    assign hz_eret = eret_d & (epc_wr_e | epc_wr_m);
    assign raw     = hz_data | hz_md | hz_eret;

    assign req   = exc_req_m;
    assign stall = raw & ~exc_req_m;
    assign clr_e = stall;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl.
// Inputs change 1ns after posedge; outputs sampled at negedge.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs_d, rt_d, a3_e, a3_m;
    logic [1:0] tuse_rs_d, tuse_rt_d, tnew_e, tnew_m;
    logic       md_use_d, eret_d, rfwr_e, rfwr_m;
    logic       epc_wr_e, epc_wr_m, md_start_e, md_is_div_e, exc_req_m;
    logic       stall, clr_e, req, md_busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .rs_d        (rs_d),
        .rt_d        (rt_d),
        .tuse_rs_d   (tuse_rs_d),
        .tuse_rt_d   (tuse_rt_d),
        .md_use_d    (md_use_d),
        .eret_d      (eret_d),
        .a3_e        (a3_e),
        .a3_m        (a3_m),
        .rfwr_e      (rfwr_e),
        .rfwr_m      (rfwr_m),
        .tnew_e      (tnew_e),
        .tnew_m      (tnew_m),
        .epc_wr_e    (epc_wr_e),
        .epc_wr_m    (epc_wr_m),
        .md_start_e  (md_start_e),
        .md_is_div_e (md_is_div_e),
        .exc_req_m   (exc_req_m),
        .stall       (stall),
        .clr_e       (clr_e),
        .req         (req),
        .md_busy     (md_busy)
    );

    task automatic idle();
        rs_d = 0; rt_d = 0; a3_e = 0; a3_m = 0;
        tuse_rs_d = 2'd3; tuse_rt_d = 2'd3;
        tnew_e = 0; tnew_m = 0;
        md_use_d = 0; eret_d = 0; rfwr_e = 0; rfwr_m = 0;
        epc_wr_e = 0; epc_wr_m = 0;
        md_start_e = 0; md_is_div_e = 0; exc_req_m = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        #12;
        tests++;
        if ({stall, clr_e, req, md_busy} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_outs got=%b want=0000",
                     {stall, clr_e, req, md_busy});
        end
        @(negedge clk);
        reset = 1'b0;
        next_cycle();
        @(negedge clk);
        tests++;
        if ({stall, clr_e, req, md_busy} !== 4'b0000) begin
            fails++;
            $display("FAIL idle_outs got=%b want=0000",
                     {stall, clr_e, req, md_busy});
        end
    endtask

    task automatic test_data_hazard();
        next_cycle();
        idle();
        rfwr_e = 1; a3_e = 8; tnew_e = 2; rs_d = 8; tuse_rs_d = 0;
        @(negedge clk);
        tests++;
        if ({stall, clr_e} !== 2'b11) begin
            fails++;
            $display("FAIL e_rs_hazard got=%b want=11", {stall, clr_e});
        end
        tuse_rs_d = 2;
        #1;
        tests++;
        if (stall !== 1'b0) begin
            fails++;
            $display("FAIL e_rs_tuse2 got=%b want=0", stall);
        end
        tuse_rs_d = 3; tnew_e = 3;
        #1;
        tests++;
        if (stall !== 1'b0) begin
            fails++;
            $display("FAIL tuse_none got=%b want=0", stall);
        end
        idle();
        rfwr_m = 1; a3_m = 17; tnew_m = 1; rt_d = 17; tuse_rt_d = 0;
        #1;
        tests++;
        if (stall !== 1'b1) begin
            fails++;
            $display("FAIL m_rt_hazard got=%b want=1", stall);
        end
        rfwr_m = 0;
        #1;
        tests++;
        if (stall !== 1'b0) begin
            fails++;
            $display("FAIL m_no_write got=%b want=0", stall);
        end
        idle();
        rfwr_m = 1; a3_m = 0; tnew_m = 1; rs_d = 0; tuse_rs_d = 0;
        #1;
        tests++;
        if (stall !== 1'b0) begin
            fails++;
            $display("FAIL zero_reg got=%b want=0", stall);
        end
        idle();
        rfwr_e = 1; a3_e = 9; tnew_e = 2; rs_d = 8; tuse_rs_d = 0;
        #1;
        tests++;
        if (stall !== 1'b0) begin
            fails++;
            $display("FAIL reg_mismatch got=%b want=0", stall);
        end
    endtask

    task automatic test_md(input logic is_div, input int n);
        next_cycle();
        idle();
        md_start_e = 1; md_is_div_e = is_div;
        @(negedge clk);
        tests++;
        if (md_busy !== 1'b1) begin
            fails++;
            $display("FAIL md_busy_c0 div=%0b got=%b want=1", is_div, md_busy);
        end
        for (int k = 1; k <= n + 1; k++) begin
            next_cycle();
            md_start_e = 0; md_is_div_e = 0; md_use_d = 1;
            @(negedge clk);
            tests++;
            if (stall !== (k <= n) || md_busy !== (k <= n)) begin
                fails++;
                $display("FAIL md_stall div=%0b cyc=%0d stall=%b busy=%b want=%b",
                         is_div, k, stall, md_busy, (k <= n));
            end
        end
    endtask

    task automatic test_exception();
        next_cycle();
        idle();
        md_start_e = 1; md_is_div_e = 1; exc_req_m = 1;
        rfwr_e = 1; a3_e = 8; tnew_e = 2; rs_d = 8; tuse_rs_d = 0;
        md_use_d = 1;
        @(negedge clk);
        tests++;
        if ({req, stall, clr_e} !== 3'b100) begin
            fails++;
            $display("FAIL exc_priority got=%b want=100", {req, stall, clr_e});
        end
        next_cycle();
        idle();
        md_use_d = 1;
        @(negedge clk);
        tests++;
        if ({md_busy, stall, req} !== 3'b000) begin
            fails++;
            $display("FAIL exc_no_load got=%b want=000", {md_busy, stall, req});
        end
    endtask

    task automatic test_exc_keeps_cnt();
        next_cycle();
        idle();
        md_start_e = 1;
        next_cycle();
        idle();
        next_cycle();
        exc_req_m = 1; md_use_d = 1;
        @(negedge clk);
        tests++;
        if ({req, stall, md_busy} !== 3'b101) begin
            fails++;
            $display("FAIL exc_running got=%b want=101", {req, stall, md_busy});
        end
        for (int k = 0; k < 5; k++) next_cycle();
        idle();
        @(negedge clk);
        tests++;
        if (md_busy !== 1'b0) begin
            fails++;
            $display("FAIL exc_running_done got=%b want=0", md_busy);
        end
    endtask

    task automatic test_eret();
        next_cycle();
        idle();
        eret_d = 1; epc_wr_m = 1;
        @(negedge clk);
        tests++;
        if (stall !== 1'b1) begin
            fails++;
            $display("FAIL eret_epc_m got=%b want=1", stall);
        end
        epc_wr_m = 0;
        #1;
        tests++;
        if (stall !== 1'b0) begin
            fails++;
            $display("FAIL eret_clear got=%b want=0", stall);
        end
        epc_wr_e = 1;
        #1;
        tests++;
        if (stall !== 1'b1) begin
            fails++;
            $display("FAIL eret_epc_e got=%b want=1", stall);
        end
        eret_d = 0;
        #1;
        tests++;
        if (stall !== 1'b0) begin
            fails++;
            $display("FAIL epc_no_eret got=%b want=0", stall);
        end
    endtask

    task automatic test_back_to_back();
        next_cycle();
        idle();
        md_start_e = 1;
        next_cycle();
        idle();
        md_use_d = 1;
        rfwr_e = 1; a3_e = 5; tnew_e = 1; rs_d = 5; tuse_rs_d = 0;
        @(negedge clk);
        tests++;
        if ({stall, clr_e} !== 2'b11) begin
            fails++;
            $display("FAIL both_stall got=%b want=11", {stall, clr_e});
        end
        for (int k = 0; k < 4; k++) next_cycle();
        @(negedge clk);
        tests++;
        if ({stall, md_busy} !== 2'b11) begin
            fails++;
            $display("FAIL both_stall_c5 got=%b want=11", {stall, md_busy});
        end
        next_cycle();
        rfwr_e = 0;
        @(negedge clk);
        tests++;
        if ({stall, md_busy} !== 2'b00) begin
            fails++;
            $display("FAIL both_release got=%b want=00", {stall, md_busy});
        end
    endtask

    task automatic test_reset_mid();
        next_cycle();
        idle();
        md_start_e = 1; md_is_div_e = 1;
        next_cycle();
        idle();
        md_use_d = 1;
        for (int k = 1; k < 7; k++) next_cycle();
        @(negedge clk);
        tests++;
        if ({md_busy, stall} !== 2'b11) begin
            fails++;
            $display("FAIL pre_reset got=%b want=11", {md_busy, stall});
        end
        #1;
        reset = 1'b1;
        #1;
        tests++;
        if ({md_busy, stall} !== 2'b00) begin
            fails++;
            $display("FAIL async_reset got=%b want=00", {md_busy, stall});
        end
        next_cycle();
        reset = 1'b0;
        next_cycle();
        @(negedge clk);
        tests++;
        if ({md_busy, stall} !== 2'b00) begin
            fails++;
            $display("FAIL post_reset got=%b want=00", {md_busy, stall});
        end
    endtask

    initial begin
        test_reset();
        test_data_hazard();
        test_md(1'b1, 10);
        test_md(1'b0, 5);
        test_exception();
        test_exc_keeps_cnt();
        test_eret();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
